// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// data_mem_responder : word-organised RV32I data memory with fixed wait states
// Rev 1.0
// ============================================================================
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT   = 4'(LATENCY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [3:0]  count, count_next;
    logic        accept, enter_resp;

    logic        op_write;
    logic [31:0] op_addr, op_wdata;
    logic [2:0]  op_funct3;

    logic        cur_write;
    logic [31:0] cur_addr, cur_wdata;
    logic [2:0]  cur_funct3;
    logic [IDX_W-1:0] cur_idx;
    logic [1:0]  lane;
    logic        idx_ok, cur_err;

    logic [31:0] rd_word, load_data;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;
    logic        mem_we;

    logic [31:0] mem [DEPTH_WORDS];

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

    // With zero latency the response is formed on the accepting edge, so the
    // live request is decoded in IDLE and the captured one in WAIT.
    always_comb begin
        if (state == IDLE) begin
            cur_write  = req_write;
            cur_addr   = req_addr;
            cur_wdata  = req_wdata;
            cur_funct3 = req_funct3;
        end else begin
            cur_write  = op_write;
            cur_addr   = op_addr;
            cur_wdata  = op_wdata;
            cur_funct3 = op_funct3;
        end
    end

    assign cur_idx = cur_addr[IDX_W+1:2];
    assign lane    = cur_addr[1:0];
    assign idx_ok  = ({2'b00, cur_addr[31:2]} < 32'(DEPTH_WORDS));

    always_comb begin
        cur_err = !idx_ok;
        case (cur_funct3)
            3'd0:    ;
            3'd1:    if (cur_addr[0]) cur_err = 1'b1;
            3'd2:    if (lane != 2'd0) cur_err = 1'b1;
            3'd4:    if (cur_write) cur_err = 1'b1;
            3'd5:    if (cur_write || cur_addr[0]) cur_err = 1'b1;
            default: cur_err = 1'b1;
        endcase
    end

    assign rd_word  = mem[cur_idx];
    assign byte_sel = rd_word[{lane, 3'b000} +: 8];
    assign half_sel = cur_addr[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_data = '0;
        case (cur_funct3)
            3'd0:    load_data = {{24{byte_sel[7]}}, byte_sel};
            3'd4:    load_data = {24'd0, byte_sel};
            3'd1:    load_data = {{16{half_sel[15]}}, half_sel};
            3'd5:    load_data = {16'd0, half_sel};
            3'd2:    load_data = rd_word;
            default: load_data = '0;
        endcase
    end

    always_comb begin
        wr_be   = 4'b0000;
        wr_data = cur_wdata;
        case (cur_funct3)
            3'd0: begin
                wr_be   = 4'b0001 << lane;
                wr_data = {4{cur_wdata[7:0]}};
            end
            3'd1: begin
                wr_be   = cur_addr[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{cur_wdata[15:0]}};
            end
            3'd2:    wr_be = 4'b1111;
            default: wr_be = 4'b0000;
        endcase
    end

    always_comb begin
        state_next = state;
        count_next = count;
        accept     = 1'b0;
        enter_resp = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (LAT == 4'd0) begin
                        state_next = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_next = WAIT;
                        count_next = LAT;
                    end
                end
            end
            WAIT: begin
                if (count <= 4'd1) begin
                    state_next = RESP;
                    count_next = 4'd0;
                    enter_resp = 1'b1;
                end else begin
                    count_next = count - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            count     <= 4'd0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            op_write  <= 1'b0;
            op_addr   <= '0;
            op_wdata  <= '0;
            op_funct3 <= 3'd0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (accept) begin
                op_write  <= req_write;
                op_addr   <= req_addr;
                op_wdata  <= req_wdata;
                op_funct3 <= req_funct3;
            end
            if (enter_resp) begin
                rsp_err   <= cur_err;
                rsp_rdata <= (cur_err || cur_write) ? 32'd0 : load_data;
            end
        end
    end

    // Storage is deliberately not reset; an aborted store never reaches here.
    assign mem_we = enter_resp && cur_write && !cur_err && !reset;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) mem[cur_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// Bench: two responders (LATENCY 0 and 2) share one random stimulus stream and
// are compared each cycle against a transaction-level memory model.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [2:0]  req_funct3 = 3'd0;
    logic        rsp_ready = 1'b1;

    logic        ready_l0, ready_l2, valid_l0, valid_l2, err_l0, err_l2;
    logic [31:0] rdata_l0, rdata_l2;

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) u_dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready_l0),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_funct3(req_funct3), .rsp_valid(valid_l0), .rsp_ready(rsp_ready),
        .rsp_rdata(rdata_l0), .rsp_err(err_l0)
    );

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_dut2 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready_l2),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_funct3(req_funct3), .rsp_valid(valid_l2), .rsp_ready(rsp_ready),
        .rsp_rdata(rdata_l2), .rsp_err(err_l2)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    bit checking = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        else
            passed++;
    endtask

    // ---------------- behavioural model ----------------
    int          lat [2] = '{0, 2};
    logic [31:0] mm [2][256];
    bit          m_busy [2] = '{0, 0};
    bit          m_vld  [2] = '{0, 0};
    int          m_left [2] = '{0, 0};
    bit          m_w    [2];
    logic [31:0] m_a    [2];
    logic [31:0] m_wd   [2];
    logic [2:0]  m_f    [2];
    bit          m_err  [2] = '{0, 0};
    logic [31:0] m_rd   [2] = '{32'd0, 32'd0};

    function automatic void model_exec(input bit w, input logic [31:0] a, input logic [31:0] wd,
                                       input logic [2:0] f, input logic [31:0] word,
                                       output bit err, output logic [31:0] rdata,
                                       output logic [31:0] nword);
        int unsigned ln, sh;
        logic [31:0] bv, hv;
        ln = a % 4;
        sh = 8 * ln;
        err = ((a / 4) >= 256);
        if ((f == 1 || f == 5) && (a % 2) != 0) err = 1;
        if (f == 2 && ln != 0) err = 1;
        if (!w && (f == 3 || f >= 6)) err = 1;
        if (w && f >= 3) err = 1;
        rdata = 0;
        nword = word;
        bv = (word >> sh) & 32'hFF;
        hv = (word >> sh) & 32'hFFFF;
        if (!err && !w) begin
            case (f)
                3'd0:    rdata = (bv >= 128) ? bv - 256 : bv;
                3'd4:    rdata = bv;
                3'd1:    rdata = (hv >= 32768) ? hv - 65536 : hv;
                3'd5:    rdata = hv;
                default: rdata = word;
            endcase
        end
        if (!err && w) begin
            case (f)
                3'd0:    nword = (word & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
                3'd1:    nword = (word & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
                default: nword = wd;
            endcase
        end
    endfunction

    function automatic void model_complete(input int k);
        logic [31:0] word, nw, rd;
        bit e;
        int unsigned idx;
        idx  = m_a[k] / 4;
        word = (idx < 256) ? mm[k][idx] : 32'd0;
        model_exec(m_w[k], m_a[k], m_wd[k], m_f[k], word, e, rd, nw);
        if (!e && m_w[k]) mm[k][idx] = nw;
        m_err[k]  = e;
        m_rd[k]   = rd;
        m_busy[k] = 0;
        m_vld[k]  = 1;
    endfunction

    always @(posedge clk or posedge reset) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_busy[k] = 0;
                m_vld[k]  = 0;
                m_left[k] = 0;
            end else if (m_vld[k]) begin
                if (rsp_ready) m_vld[k] = 0;
            end else if (m_busy[k]) begin
                m_left[k]--;
                if (m_left[k] == 0) model_complete(k);
            end else if (req_valid) begin
                m_w[k]    = req_write;
                m_a[k]    = req_addr;
                m_wd[k]   = req_wdata;
                m_f[k]    = req_funct3;
                m_left[k] = lat[k];
                if (m_left[k] == 0) model_complete(k);
                else m_busy[k] = 1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic        dut_rdy [2], dut_val [2], dut_err [2];
    logic [31:0] dut_dat [2];
    assign dut_rdy[0] = ready_l0;  assign dut_rdy[1] = ready_l2;
    assign dut_val[0] = valid_l0;  assign dut_val[1] = valid_l2;
    assign dut_err[0] = err_l0;    assign dut_err[1] = err_l2;
    assign dut_dat[0] = rdata_l0;  assign dut_dat[1] = rdata_l2;

    always @(negedge clk) begin
        if (checking) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("model_req_ready[%0d]", k), 32'(dut_rdy[k]), 32'(!(m_busy[k] || m_vld[k])));
                chk($sformatf("model_rsp_valid[%0d]", k), 32'(dut_val[k]), 32'(m_vld[k]));
                if (m_vld[k]) begin
                    chk($sformatf("model_rsp_err[%0d]", k), 32'(dut_err[k]), 32'(m_err[k]));
                    chk($sformatf("model_rsp_rdata[%0d]", k), dut_dat[k], m_rd[k]);
                end
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wait_idle();
        int n = 0;
        while (!(ready_l0 && ready_l2) && n < 40) begin
            @(negedge clk); #1;
            n++;
        end
        chk("idle_wait_bound", 32'(n < 40), 32'd1);
    endtask

    task automatic txn(input bit w, input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f,
                       input bit xe, input logic [31:0] xd0, input logic [31:0] xd2, input string nm);
        int e0 = -1;
        int e2 = -1;
        wait_idle();
        req_valid = 1; req_write = w; req_addr = a; req_wdata = wd; req_funct3 = f;
        rsp_ready = 1;
        for (int c = 1; c <= 20 && e2 < 0; c++) begin
            @(negedge clk); #1;
            if (c == 1) begin
                req_valid = 0; req_addr = $urandom; req_wdata = $urandom;
            end
            if (e0 < 0 && valid_l0) begin
                e0 = c;
                chk({nm, "_err_l0"}, 32'(err_l0), 32'(xe));
                chk({nm, "_rdata_l0"}, rdata_l0, xd0);
            end
            if (e2 < 0 && valid_l2) begin
                e2 = c;
                chk({nm, "_err_l2"}, 32'(err_l2), 32'(xe));
                chk({nm, "_rdata_l2"}, rdata_l2, xd2);
            end
        end
        chk({nm, "_latency_l0"}, 32'(e0), 32'd1);
        chk({nm, "_latency_l2"}, 32'(e2), 32'd3);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1 reset = 0;
        checking = 1;
        chk("reset_req_ready", 32'({ready_l0, ready_l2}), 32'h3);
        chk("reset_rsp_valid", 32'({valid_l0, valid_l2}), 32'h0);
        chk("reset_rdata", rdata_l2, 32'd0);

        for (int i = 0; i < 16; i++)
            txn(1, 32'(i * 4), 32'hC0DE0000 | 32'(i), 3'd2, 0, 32'd0, 32'd0, "preload");

        txn(1, 32'h10, 32'hDEADBEEF, 3'd2, 0, 32'd0, 32'd0, "sw_10");
        txn(0, 32'h10, 32'd0, 3'd2, 0, 32'hDEADBEEF, 32'hDEADBEEF, "lw_10");
        txn(0, 32'h13, 32'd0, 3'd0, 0, 32'hFFFFFFDE, 32'hFFFFFFDE, "lb_13");
        txn(0, 32'h13, 32'd0, 3'd4, 0, 32'h000000DE, 32'h000000DE, "lbu_13");
        txn(0, 32'h10, 32'd0, 3'd1, 0, 32'hFFFFBEEF, 32'hFFFFBEEF, "lh_10");
        txn(0, 32'h12, 32'd0, 3'd5, 0, 32'h0000DEAD, 32'h0000DEAD, "lhu_12");
        txn(1, 32'h11, 32'h000000AA, 3'd0, 0, 32'd0, 32'd0, "sb_11");
        txn(0, 32'h10, 32'd0, 3'd2, 0, 32'hDEADAAEF, 32'hDEADAAEF, "lw_after_sb");
        txn(1, 32'h12, 32'h00001234, 3'd1, 0, 32'd0, 32'd0, "sh_12");
        txn(0, 32'h10, 32'd0, 3'd2, 0, 32'h1234AAEF, 32'h1234AAEF, "lw_after_sh");

        txn(0, 32'h12, 32'd0, 3'd2, 1, 32'd0, 32'd0, "err_lw_misalign");
        txn(1, 32'h11, 32'hFFFF, 3'd1, 1, 32'd0, 32'd0, "err_sh_misalign");
        txn(0, 32'h400, 32'd0, 3'd2, 1, 32'd0, 32'd0, "err_range");
        txn(0, 32'h10, 32'd0, 3'd3, 1, 32'd0, 32'd0, "err_funct3");
        txn(1, 32'h10, 32'hFFFFFFFF, 3'd4, 1, 32'd0, 32'd0, "err_store_f3");
        txn(0, 32'h10, 32'd0, 3'd2, 0, 32'h1234AAEF, 32'h1234AAEF, "reread_after_err");

        // Response stall with competing requests that must be ignored.
        wait_idle();
        req_valid = 1; req_write = 0; req_addr = 32'h10; req_funct3 = 3'd2; rsp_ready = 0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk); #1;
            if (c >= 3 && c <= 7) begin
                chk("stall_valid", 32'({valid_l0, valid_l2}), 32'h3);
                chk("stall_ready", 32'({ready_l0, ready_l2}), 32'h0);
                chk("stall_rdata_l2", rdata_l2, 32'h1234AAEF);
                chk("stall_err_l2", 32'(err_l2), 32'd0);
                req_valid = 1; req_write = 1; req_addr = 32'h10;
                req_wdata = $urandom; req_funct3 = 3'd2;
            end else begin
                req_valid = 0;
            end
            if (c == 8) rsp_ready = 1;
            if (c == 9) begin
                chk("release_ready", 32'({ready_l0, ready_l2}), 32'h3);
                chk("release_valid", 32'({valid_l0, valid_l2}), 32'h0);
            end
        end
        txn(0, 32'h10, 32'd0, 3'd2, 0, 32'h1234AAEF, 32'h1234AAEF, "reread_after_stall");

        // Reset while the latency-2 store is still waiting.
        wait_idle();
        req_valid = 1; req_write = 1; req_addr = 32'h20; req_wdata = 32'h55; req_funct3 = 3'd2;
        rsp_ready = 1;
        @(negedge clk); #1;
        req_valid = 0;
        chk("abort_pre_valid_l0", 32'(valid_l0), 32'd1);
        chk("abort_pre_valid_l2", 32'(valid_l2), 32'd0);
        reset = 1;
        #1;
        chk("abort_valid", 32'({valid_l0, valid_l2}), 32'h0);
        chk("abort_err", 32'({err_l0, err_l2}), 32'h0);
        chk("abort_rdata_l0", rdata_l0, 32'd0);
        @(negedge clk); #1;
        reset = 0;
        txn(0, 32'h20, 32'd0, 3'd2, 0, 32'h00000055, 32'hC0DE0008, "lw_20_after_abort");

        // Randomised traffic, including occasional reset pulses.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk); #1;
            reset      = ($urandom_range(0, 299) == 0);
            req_valid  = $urandom_range(0, 1);
            req_write  = $urandom_range(0, 1);
            req_funct3 = 3'($urandom_range(0, 7));
            req_wdata  = $urandom;
            if ($urandom_range(0, 9) == 0) req_addr = 32'h400 + 32'($urandom_range(0, 63));
            else                           req_addr = 32'($urandom_range(0, 63));
            rsp_ready  = ($urandom_range(0, 9) < 7);
        end
        reset = 0; req_valid = 0; rsp_ready = 1;
        repeat (20) @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
